// File: rtl/cp_pixel_buffer.sv
// Ping-pong tile buffer: DMA side writes 4 byte lanes per beat into the write bank,
// rotation side reads one {B,G,R} triple per cycle from the read bank.
module cp_pixel_buffer #(
  parameter int P_DEPTH = 192
) (
  input  logic        I_PB_HCLK,
  input  logic        I_PB_HRESET_N,
  input  logic        I_PB_CLEAR,
  input  logic        I_PB_WRITE,
  input  logic        I_PB_PAD,
  input  logic [31:0] I_PB_WDATA,
  input  logic [7:0]  I_PB_WADDR0,
  input  logic [7:0]  I_PB_WADDR1,
  input  logic [7:0]  I_PB_WADDR2,
  input  logic [7:0]  I_PB_WADDR3,
  input  logic        I_PB_WDONE,
  input  logic        I_PB_READ,
  input  logic [7:0]  I_PB_RADDRR,
  input  logic [7:0]  I_PB_RADDRG,
  input  logic [7:0]  I_PB_RADDRB,
  input  logic        I_PB_RDONE,
  output logic [23:0] O_PB_RDATA,
  output logic        O_PB_RVALID,
  output logic        O_PB_WR_AVAIL,
  output logic        O_PB_RD_AVAIL,
  output logic [1:0]  O_PB_LEVEL,
  output logic [2:0]  O_PB_ERR
);

  localparam logic [8:0] LP_DEPTH = 9'(P_DEPTH);

  logic [7:0]  r_mem [2][P_DEPTH];
  logic [1:0]  r_full;
  logic        r_wsel;
  logic        r_rsel;
  logic [2:0]  r_err;
  logic [23:0] r_rdata_p1;
  logic        r_rvld_p1;

  logic [7:0]  w_waddr [4];
  logic [7:0]  w_raddr [3];
  logic [7:0]  w_rbyte [3];
  logic        w_wr_full;
  logic        w_rd_full;
  logic        w_wr_ok;
  logic        w_wr_range;
  logic        w_rd_range;
  logic [1:0]  w_full_nxt;
  logic [2:0]  w_err_set;

  function automatic logic f_in_range(input logic [7:0] addr);
    return ({1'b0, addr} < LP_DEPTH);
  endfunction

  assign w_waddr[0] = I_PB_WADDR0;
  assign w_waddr[1] = I_PB_WADDR1;
  assign w_waddr[2] = I_PB_WADDR2;
  assign w_waddr[3] = I_PB_WADDR3;
  assign w_raddr[0] = I_PB_RADDRR;
  assign w_raddr[1] = I_PB_RADDRG;
  assign w_raddr[2] = I_PB_RADDRB;

  assign w_wr_full = r_full[r_wsel];
  assign w_rd_full = r_full[r_rsel];
  assign w_wr_ok   = I_PB_WRITE & ~w_wr_full & ~I_PB_CLEAR;

  always_comb begin
    w_wr_range = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!f_in_range(w_waddr[k])) w_wr_range = 1'b1;
    end
    w_rd_range = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_rbyte[k] = 8'h00;
      if (f_in_range(w_raddr[k])) w_rbyte[k] = r_mem[r_rsel][w_raddr[k]];
      else                        w_rd_range = 1'b1;
    end
  end

  // WDONE needs an empty write bank and RDONE a full read bank, so when both
  // point at the same bank at most one of them can act on it.
  always_comb begin
    w_full_nxt = r_full;
    if (I_PB_WDONE && !w_wr_full) w_full_nxt[r_wsel] = 1'b1;
    if (I_PB_RDONE &&  w_rd_full) w_full_nxt[r_rsel] = 1'b0;
  end

  always_comb begin
    w_err_set    = 3'b000;
    w_err_set[2] = (I_PB_WRITE && !w_wr_full && w_wr_range) ||
                   (I_PB_READ  &&  w_rd_full && w_rd_range);
    w_err_set[1] = (I_PB_WRITE || I_PB_WDONE) &&  w_wr_full;
    w_err_set[0] = (I_PB_READ  || I_PB_RDONE) && !w_rd_full;
  end

  // Lanes are applied in ascending order so the highest lane wins an address clash.
  always_ff @(posedge I_PB_HCLK) begin
    if (w_wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (f_in_range(w_waddr[k]))
          r_mem[r_wsel][w_waddr[k]] <= I_PB_PAD ? 8'h00 : I_PB_WDATA[8*k +: 8];
      end
    end
  end

  // Stage p1: registered read result and control state.
  always_ff @(posedge I_PB_HCLK or negedge I_PB_HRESET_N) begin
    if (!I_PB_HRESET_N) begin
      r_full     <= 2'b00;
      r_wsel     <= 1'b0;
      r_rsel     <= 1'b0;
      r_err      <= 3'b000;
      r_rvld_p1  <= 1'b0;
      r_rdata_p1 <= 24'h0;
    end else if (I_PB_CLEAR) begin
      r_full     <= 2'b00;
      r_wsel     <= 1'b0;
      r_rsel     <= 1'b0;
      r_err      <= 3'b000;
      r_rvld_p1  <= 1'b0;
      r_rdata_p1 <= 24'h0;
    end else begin
      r_full    <= w_full_nxt;
      r_err     <= r_err | w_err_set;
      r_rvld_p1 <= I_PB_READ;
      if (I_PB_WDONE && !w_wr_full) r_wsel <= ~r_wsel;
      if (I_PB_RDONE &&  w_rd_full) r_rsel <= ~r_rsel;
      if (I_PB_READ)
        r_rdata_p1 <= w_rd_full ? {w_rbyte[2], w_rbyte[1], w_rbyte[0]} : 24'h0;
    end
  end

  assign O_PB_RDATA    = r_rdata_p1;
  assign O_PB_RVALID   = r_rvld_p1;
  assign O_PB_WR_AVAIL = ~w_wr_full;
  assign O_PB_RD_AVAIL = w_rd_full;
  assign O_PB_LEVEL    = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign O_PB_ERR      = r_err;

endmodule

// File: tb/tb_cp_pixel_buffer.sv
// Directed bench for cp_pixel_buffer: fill/read, pad, ping-pong, underflow,
// range, lane collision, soft clear and async reset.
module tb_cp_pixel_buffer;

  logic        clk;
  logic        rst_n;
  logic        clear, write, pad, wdone, read, rdone;
  logic [31:0] wdata;
  logic [7:0]  wa0, wa1, wa2, wa3, rar, rag, rab;
  logic [23:0] rdata;
  logic        rvalid, wr_avail, rd_avail;
  logic [1:0]  level;
  logic [2:0]  err;

  int n_chk  = 0;
  int n_pass = 0;

  cp_pixel_buffer #(.P_DEPTH(192)) dut (
    .I_PB_HCLK(clk), .I_PB_HRESET_N(rst_n), .I_PB_CLEAR(clear),
    .I_PB_WRITE(write), .I_PB_PAD(pad), .I_PB_WDATA(wdata),
    .I_PB_WADDR0(wa0), .I_PB_WADDR1(wa1), .I_PB_WADDR2(wa2), .I_PB_WADDR3(wa3),
    .I_PB_WDONE(wdone), .I_PB_READ(read),
    .I_PB_RADDRR(rar), .I_PB_RADDRG(rag), .I_PB_RADDRB(rab),
    .I_PB_RDONE(rdone), .O_PB_RDATA(rdata), .O_PB_RVALID(rvalid),
    .O_PB_WR_AVAIL(wr_avail), .O_PB_RD_AVAIL(rd_avail),
    .O_PB_LEVEL(level), .O_PB_ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; write = 0; pad = 0; wdone = 0; read = 0; rdone = 0;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3, input logic p);
    write = 1; pad = p; wdata = d; wa0 = a0; wa1 = a1; wa2 = a2; wa3 = a3;
    tick();
    write = 0; pad = 0;
  endtask

  // Fill a bank so that byte at address a holds a ^ x.
  task automatic fill(input logic [7:0] x);
    logic [7:0] a;
    logic [31:0] d;
    for (int i = 0; i < 48; i++) begin
      a = 8'(4 * i);
      d = {(a + 8'd3) ^ x, (a + 8'd2) ^ x, (a + 8'd1) ^ x, a ^ x};
      wr_beat(d, a, a + 8'd1, a + 8'd2, a + 8'd3, 1'b0);
    end
  endtask

  task automatic pulse_wdone();
    wdone = 1; tick(); wdone = 0;
  endtask

  task automatic pulse_rdone();
    rdone = 1; tick(); rdone = 0;
  endtask

  task automatic rd(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [23:0] exp, input string tag);
    read = 1; rar = r; rag = g; rab = b;
    tick();
    read = 0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, 32'(rdata), 32'(exp));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_wr_avail"}, 32'(wr_avail), 32'd1);
    chk({tag, "_rd_avail"}, 32'(rd_avail), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    idle();
    wdata = 0; wa0 = 0; wa1 = 0; wa2 = 0; wa3 = 0; rar = 0; rag = 0; rab = 0;
    rst_n = 0;
    #17;
    chk_reset_outs("reset");
    @(negedge clk); rst_n = 1;
    tick();

    // Underflow after reset
    rd(8'd0, 8'd1, 8'd2, 24'h0, "uf_read");
    chk("uf_err", 32'(err), 32'b001);
    pulse_rdone();
    chk("uf_rdone_level", 32'(level), 32'd0);
    chk("uf_rvalid_drop", 32'(rvalid), 32'd0);
    clear = 1; tick(); clear = 0;
    chk("uf_clear_err", 32'(err), 32'd0);

    // Fill bank A then read
    fill(8'h00);
    chk("fill_no_avail_yet", 32'(rd_avail), 32'd0);
    pulse_wdone();
    chk("fill_rd_avail", 32'(rd_avail), 32'd1);
    chk("fill_level", 32'(level), 32'd1);
    chk("fill_wr_avail", 32'(wr_avail), 32'd1);
    rd(8'h15, 8'h16, 8'h17, 24'h171615, "fill_read");
    tick();
    chk("hold_rvalid", 32'(rvalid), 32'd0);
    chk("hold_rdata", 32'(rdata), 32'h171615);
    // Back-to-back reads
    read = 1; rar = 8'd0; rag = 8'd1; rab = 8'd2;
    tick();
    chk("b2b0", 32'(rdata), 32'h020100);
    rar = 8'd3; rag = 8'd4; rab = 8'd5;
    tick();
    read = 0;
    chk("b2b1", 32'(rdata), 32'h050403);
    chk("b2b1_rvalid", 32'(rvalid), 32'd1);

    // Ping-pong: bank B holds a ^ A5
    fill(8'hA5);
    pulse_wdone();
    chk("pp_level2", 32'(level), 32'd2);
    chk("pp_wr_avail0", 32'(wr_avail), 32'd0);
    wr_beat(32'h11223344, 8'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    chk("pp_overflow", 32'(err), 32'b010);
    write = 1; rdone = 1; wdata = 32'h99999999; wa0 = 8'd0; wa1 = 8'd1; wa2 = 8'd2; wa3 = 8'd3;
    tick();
    write = 0; rdone = 0;
    chk("pp_level1", 32'(level), 32'd1);
    chk("pp_wr_avail1", 32'(wr_avail), 32'd1);
    chk("pp_rd_avail", 32'(rd_avail), 32'd1);
    rd(8'h15, 8'h16, 8'h17, 24'hB2B3B0, "pp_bankB");

    // Range: lane0 out of range, others in range into bank A
    wr_beat(32'h77665544, 8'hC0, 8'h40, 8'h41, 8'h42, 1'b0);
    chk("rng_wr_err", 32'(err), 32'b110);
    rd(8'hBF, 8'hC1, 8'h10, 24'hB5001A, "rng_read");
    chk("rng_rd_err", 32'(err), 32'b110);

    // Soft clear, then collision + pad into bank A (old contents remain)
    clear = 1; tick(); clear = 0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_level", 32'(level), 32'd0);
    wr_beat(32'h44332211, 8'h30, 8'h30, 8'h30, 8'h30, 1'b0);
    wr_beat(32'hDEADBEEF, 8'd0, 8'd1, 8'd2, 8'd3, 1'b1);
    pulse_wdone();
    rd(8'd0, 8'd1, 8'd2, 24'h000000, "pad_read");
    chk("pad_err", 32'(err), 32'd0);
    rd(8'h30, 8'h31, 8'h32, 24'h323144, "coll_read");
    rd(8'h40, 8'h41, 8'h42, 24'h776655, "rng_inrange");

    // Clear with level 2, err set, read strobe active
    pulse_wdone();
    chk("cl_level2", 32'(level), 32'd2);
    wr_beat(32'h0, 8'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    chk("cl_err_set", 32'(err), 32'b010);
    clear = 1; read = 1; rar = 8'h30; rag = 8'h31; rab = 8'h32;
    tick();
    clear = 0; read = 0;
    chk("cl_level", 32'(level), 32'd0);
    chk("cl_err", 32'(err), 32'd0);
    chk("cl_rvalid", 32'(rvalid), 32'd0);
    chk("cl_rdata", 32'(rdata), 32'h0);

    // Async reset mid-cycle
    pulse_wdone();
    read = 1; rar = 8'h30; rag = 8'h31; rab = 8'h32;
    tick();
    read = 0;
    chk("pre_rst_rdata", 32'(rdata), 32'h323144);
    #2;
    rst_n = 0;
    #1;
    chk_reset_outs("async_rst");
    #10;
    rst_n = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cp_pixel_buffer.md
# cp_pixel_buffer

Ping-pong input pixel buffer sitting between the AHB DMA read path and the rotation core. It stores one 64-pixel RGB tile (192 bytes) per bank: the DMA side writes four byte lanes per beat at core-supplied byte addresses, and the rotation side reads one R/G/B triple per cycle at rotated addresses. Two banks let the next tile fill while the current one drains. Per-bank full flags and sticky error flags give the DMA and rotation core a simple handshake.

## Interface
Parameters:
- P_DEPTH, 192, bytes per bank; legal byte addresses are 0..P_DEPTH-1.

Ports:
- I_PB_HCLK  in  1  system clock, all state on rising edge.
- I_PB_HRESET_N  in  1  reset, asynchronous assert, active-low.
- I_PB_CLEAR  in  1  synchronous soft clear of pointers, flags and errors (memory untouched).
- I_PB_WRITE  in  1  byte-lane write strobe.
- I_PB_PAD  in  1  when 1, all four written bytes are 8'h00 instead of data.
- I_PB_WDATA  in  32  beat data; lane k = bits [8k+7:8k].
- I_PB_WADDR0..I_PB_WADDR3  in  8 each  byte address for lane 0..3.
- I_PB_WDONE  in  1  pulse: current write bank complete.
- I_PB_READ  in  1  triple read strobe.
- I_PB_RADDRR / I_PB_RADDRG / I_PB_RADDRB  in  8 each  byte addresses of R, G, B.
- I_PB_RDONE  in  1  pulse: current read bank consumed.
- O_PB_RDATA  out  24  {B,G,R} read result.
- O_PB_RVALID  out  1  O_PB_RDATA valid this cycle.
- O_PB_WR_AVAIL  out  1  current write bank not full.
- O_PB_RD_AVAIL  out  1  current read bank full.
- O_PB_LEVEL  out  2  number of full banks (0..2).
- O_PB_ERR  out  3  sticky {range, overflow, underflow}.

## Operation
- State: two memories of P_DEPTH bytes, full[1:0], wsel, rsel, O_PB_ERR. Memory is not reset. All other state resets to 0.
- Write, on I_PB_WRITE and !full[wsel]:
  - Each lane whose address is < P_DEPTH writes its byte (or 8'h00 if I_PB_PAD) into bank wsel.
  - Lanes with an out-of-range address are dropped and set ERR[2].
  - If two lanes hit the same address, the higher lane index wins.
- Write while full[wsel]: all lanes dropped, ERR[1] set.
- WDONE with !full[wsel]: full[wsel] <= 1 and wsel toggles. WDONE with full[wsel]: ignored, ERR[1] set.
- Read, on I_PB_READ:
  - If full[rsel], each of R/G/B returns its byte from bank rsel; an out-of-range address returns 8'h00 and sets ERR[2].
  - If !full[rsel], the result is 24'h0 and ERR[0] is set.
  - O_PB_RVALID pulses in both cases.
- RDONE with full[rsel]: full[rsel] <= 0 and rsel toggles. RDONE with !full[rsel]: ignored, ERR[0] set.
- O_PB_WR_AVAIL = !full[wsel]; O_PB_RD_AVAIL = full[rsel]; O_PB_LEVEL = full[0]+full[1]. All are combinational from registers.
- I_PB_CLEAR has priority over every other input in that cycle:
  - full, wsel, rsel, ERR, O_PB_RVALID and O_PB_RDATA all go to 0.
  - Write and read strobes in that cycle are discarded.
- ERR bits clear only on reset or I_PB_CLEAR.

## Timing
- Reset outputs: O_PB_RDATA 0, O_PB_RVALID 0, O_PB_WR_AVAIL 1, O_PB_RD_AVAIL 0, O_PB_LEVEL 0, O_PB_ERR 0.
- Write latency: data is stored at the strobe edge and is readable once the bank has been handed over by WDONE and becomes the read bank.
- Read latency: 1 cycle. Address sampled at edge N; O_PB_RDATA/O_PB_RVALID are registered and valid for cycle N+1 only. O_PB_RDATA holds its value when RVALID is 0.
- Back-to-back reads are allowed every cycle at full throughput.
- Write in the same cycle as WDONE goes to the pre-toggle bank, and that bank's full check uses pre-edge state.
- Read in the same cycle as RDONE uses the pre-toggle bank; its data still appears next cycle.
- WDONE and RDONE in the same cycle are both applied, each against pre-edge flags. With banks on different sides this is a simultaneous hand-over.
- Reset asserted mid-operation clears state immediately (async) and drops RVALID. Memory contents survive but are unreachable until refilled.

## Test plan
- Fill then read:
  - Stimulus: 48 beats writing ascending bytes 0..191, lanes at addresses 4i..4i+3; WDONE; then reads R/G/B = 0x15/0x16/0x17.
  - Required: O_PB_RD_AVAIL=1 and LEVEL=1 after WDONE; the read returns O_PB_RDATA=24'h171615 one cycle later with RVALID high.
- Pad:
  - Stimulus: write beat WDATA=32'hDEADBEEF at 0..3 with I_PB_PAD=1; WDONE; read 0/1/2.
  - Required: RDATA=24'h000000, ERR=0.
- Ping-pong:
  - Stimulus: fill bank A, WDONE, fill bank B, WDONE.
  - Required after second WDONE: LEVEL=2, WR_AVAIL=0.
  - Stimulus: a further write, then RDONE in the same cycle as a write.
  - Required: the further write sets ERR=3'b010; after RDONE, LEVEL=1 and reads return bank B data.
- Underflow:
  - Stimulus: after reset, READ at addresses 0/1/2.
  - Required: RVALID=1, RDATA=0, ERR=3'b001.
  - Stimulus: RDONE.
  - Required: LEVEL stays 0.
- Range:
  - Stimulus: write lane0 at address 0xC0, then read R at 0xBF, G at 0xC1.
  - Required: ERR[2]=1, the G byte reads 0, and the in-range bytes are unaffected.
- Reset/clear:
  - Stimulus: with LEVEL=2 and ERR nonzero, pulse I_PB_CLEAR while READ=1.
  - Required: next cycle LEVEL=0, ERR=0, RVALID=0.
  - Stimulus: assert I_PB_HRESET_N low mid-cycle.
  - Required: outputs go to reset values before the next edge.
